// File: rtl/resp_router.sv
// Return-path router: steers an in-order response stream to the requester port
// that issued each request, using a tag FIFO of accepted-request port IDs.
module resp_router #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PORTS      = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                clk_in,
  input  logic                                rst_N_in,
  input  logic                                req_fire_in,
  input  logic [$clog2(PORTS)-1:0]            req_id_in,
  output logic                                tag_full_out,
  output logic [$clog2(DEPTH+1)-1:0]          outstanding_out,
  input  logic                                resp_valid_in,
  input  logic [DATA_WIDTH-1:0]               resp_data_in,
  output logic                                resp_ready_out,
  output logic [PORTS-1:0]                    port_valid_out,
  output logic [PORTS-1:0][DATA_WIDTH-1:0]    port_data_out,
  input  logic [PORTS-1:0]                    port_ready_in,
  output logic                                error_out
);

  localparam int unsigned ID_W  = $clog2(PORTS);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]       r_tags [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_out_valid;
  logic [ID_W-1:0]       r_out_id;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_error;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_ready;
  logic                  w_drain;
  logic                  w_err_evt;
  logic [ID_W-1:0]       w_head;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_tags[r_rd_ptr];

  // Ready of the port owning the held beat; an ID with no matching port drains on its own.
  always_comb begin
    w_sel_ready = 1'b1;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (r_out_id == ID_W'(i)) begin
        w_sel_ready = port_ready_in[i];
      end
    end
  end

  assign w_drain        = r_out_valid && w_sel_ready;
  assign resp_ready_out = !w_empty && (!r_out_valid || w_sel_ready);
  assign w_pop          = resp_valid_in && resp_ready_out;
  // Full check uses the pre-pop count, so a push at full is dropped even alongside a pop.
  assign w_push         = req_fire_in && !w_full;
  assign w_err_evt      = (req_fire_in && w_full) || (resp_valid_in && w_empty);

  // Tag storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= req_id_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-entry output register; a drain and a load may happen in the same cycle.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_id    <= w_head;
      r_out_data  <= resp_data_in;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_error <= 1'b0;
    end else if (w_err_evt) begin
      r_error <= 1'b1;
    end
  end

  always_comb begin
    port_valid_out = '0;
    port_data_out  = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      port_valid_out[i] = r_out_valid && (r_out_id == ID_W'(i));
      port_data_out[i]  = r_out_data;
    end
  end

  assign tag_full_out    = w_full;
  assign outstanding_out = r_count;
  assign error_out       = r_error;

endmodule

// File: tb/tb_resp_router.sv
// Directed and randomized checks of resp_router against a queue-based model
// of in-order response routing.
module tb_resp_router;

  localparam int unsigned DW    = 64;
  localparam int unsigned PORTS = 4;
  localparam int unsigned DEPTH = 4;

  logic               clk_in = 1'b0;
  logic               rst_N_in = 1'b1;
  logic               req_fire_in;
  logic [1:0]         req_id_in;
  logic               tag_full_out;
  logic [2:0]         outstanding_out;
  logic               resp_valid_in;
  logic [DW-1:0]      resp_data_in;
  logic               resp_ready_out;
  logic [PORTS-1:0]   port_valid_out;
  logic [PORTS-1:0][DW-1:0] port_data_out;
  logic [PORTS-1:0]   port_ready_in;
  logic               error_out;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue of outstanding port IDs plus the beat currently presented.
  int          q[$];
  bit          m_valid;
  int          m_id;
  logic [DW-1:0] m_data;
  bit          m_err;

  resp_router #(.DATA_WIDTH(DW), .PORTS(PORTS), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .req_fire_in(req_fire_in), .req_id_in(req_id_in),
    .tag_full_out(tag_full_out), .outstanding_out(outstanding_out),
    .resp_valid_in(resp_valid_in), .resp_data_in(resp_data_in),
    .resp_ready_out(resp_ready_out),
    .port_valid_out(port_valid_out), .port_data_out(port_data_out),
    .port_ready_in(port_ready_in), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [PORTS-1:0] exp_pv;
    exp_pv = '0;
    if (m_valid && m_id < int'(PORTS)) exp_pv[m_id] = 1'b1;
    chk({tag, "_outstanding"}, DW'(outstanding_out), DW'(q.size()));
    chk({tag, "_full"}, DW'(tag_full_out), DW'(q.size() == int'(DEPTH)));
    chk({tag, "_pvalid"}, DW'(port_valid_out), DW'(exp_pv));
    for (int i = 0; i < int'(PORTS); i++) begin
      chk({tag, "_pdata"}, port_data_out[i], m_data);
    end
    chk({tag, "_error"}, DW'(error_out), DW'(m_err));
  endtask

  task automatic model_clear();
    q.delete();
    m_valid = 1'b0;
    m_id    = 0;
    m_data  = '0;
    m_err   = 1'b0;
  endtask

  // Asynchronous reset asserted away from the clock edge, released after one edge.
  task automatic do_reset();
    req_fire_in = 1'b0; resp_valid_in = 1'b0; port_ready_in = '0;
    req_id_in = '0; resp_data_in = '0;
    rst_N_in = 1'b0;
    model_clear();
    #1;
    chk("rst_async_ready", DW'(resp_ready_out), '0);
    check_outputs("rst_async");
    @(posedge clk_in); #1;
    check_outputs("rst_hold");
    rst_N_in = 1'b1;
  endtask

  // One clock cycle: apply inputs, check the combinational ready, advance model, check outputs.
  task automatic step(input logic fire, input logic [1:0] id, input logic rv,
                      input logic [DW-1:0] data, input logic [PORTS-1:0] rdy);
    bit exp_rr, push, pop, sel_rdy;
    req_fire_in = fire; req_id_in = id; resp_valid_in = rv;
    resp_data_in = data; port_ready_in = rdy;
    #1;
    sel_rdy = (m_id >= int'(PORTS)) ? 1'b1 : rdy[m_id];
    exp_rr  = (q.size() > 0) && (!m_valid || sel_rdy);
    chk("resp_ready", DW'(resp_ready_out), DW'(exp_rr));
    push = fire && (q.size() < int'(DEPTH));
    pop  = rv && exp_rr;
    if ((fire && q.size() == int'(DEPTH)) || (rv && q.size() == 0)) m_err = 1'b1;
    if (pop) begin
      m_id    = q.pop_front();
      m_valid = 1'b1;
      m_data  = data;
    end else if (m_valid && sel_rdy) begin
      m_valid = 1'b0;
    end
    if (push) q.push_back(int'(id));
    @(posedge clk_in); #1;
    check_outputs("step");
  endtask

  initial begin
    logic [DW-1:0] rd;
    req_fire_in = 1'b0; req_id_in = '0; resp_valid_in = 1'b0;
    resp_data_in = '0; port_ready_in = '0;
    model_clear();
    #2;
    do_reset();

    // In-order routing: IDs 2,0,3 then three back-to-back responses.
    step(1'b1, 2'd2, 1'b0, '0, 4'hF);
    step(1'b1, 2'd0, 1'b0, '0, 4'hF);
    step(1'b1, 2'd3, 1'b0, '0, 4'hF);
    chk("order_outstanding3", DW'(outstanding_out), DW'(3));
    step(1'b0, 2'd0, 1'b1, DW'(64'hA), 4'hF);
    chk("order_a_valid", DW'(port_valid_out), DW'(4'b0100));
    chk("order_a_data", port_data_out[2], DW'(64'hA));
    step(1'b0, 2'd0, 1'b1, DW'(64'hB), 4'hF);
    chk("order_b_valid", DW'(port_valid_out), DW'(4'b0001));
    chk("order_b_data", port_data_out[0], DW'(64'hB));
    step(1'b0, 2'd0, 1'b1, DW'(64'hC), 4'hF);
    chk("order_c_valid", DW'(port_valid_out), DW'(4'b1000));
    chk("order_c_data", port_data_out[3], DW'(64'hC));
    chk("order_outstanding0", DW'(outstanding_out), DW'(0));
    step(1'b0, 2'd0, 1'b0, '0, 4'hF);

    // Back-pressure: port 1 holds its beat while the next response waits.
    step(1'b1, 2'd1, 1'b0, '0, 4'hF);
    step(1'b1, 2'd2, 1'b0, '0, 4'hF);
    step(1'b0, 2'd0, 1'b1, DW'(64'hD0D0), 4'hF);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b1, DW'(64'hE0E0), 4'b1101);
      chk("bp_hold_valid", DW'(port_valid_out), DW'(4'b0010));
      chk("bp_hold_data", port_data_out[1], DW'(64'hD0D0));
    end
    step(1'b0, 2'd0, 1'b1, DW'(64'hE0E0), 4'hF);
    chk("bp_pass_valid", DW'(port_valid_out), DW'(4'b0100));
    chk("bp_pass_data", port_data_out[2], DW'(64'hE0E0));
    step(1'b0, 2'd0, 1'b0, '0, 4'hF);

    // Mid-stream reset with three tags held and a beat presented.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, '0, 4'h0);
    step(1'b0, 2'd0, 1'b1, DW'(64'h1234), 4'h0);
    chk("mid_outstanding", DW'(outstanding_out), DW'(3));
    chk("mid_valid", DW'(port_valid_out), DW'(4'b0001));
    #2;
    do_reset();

    // Full: fifth fire is dropped and flags an error; one pop clears full.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(3 - i), 1'b0, '0, 4'hF);
    chk("full_flag", DW'(tag_full_out), DW'(1));
    step(1'b1, 2'd1, 1'b0, '0, 4'hF);
    chk("full_error", DW'(error_out), DW'(1));
    chk("full_count", DW'(outstanding_out), DW'(4));
    step(1'b0, 2'd0, 1'b1, DW'(64'h55), 4'hF);
    chk("full_cleared", DW'(tag_full_out), DW'(0));
    chk("full_first_id", DW'(port_valid_out), DW'(4'b1000));
    #2;
    do_reset();

    // Empty: response at count 0 stalls even with a same-cycle push.
    step(1'b1, 2'd1, 1'b1, DW'(64'h77), 4'hF);
    chk("empty_error", DW'(error_out), DW'(1));
    chk("empty_no_valid", DW'(port_valid_out), DW'(0));
    step(1'b0, 2'd0, 1'b1, DW'(64'h77), 4'hF);
    chk("empty_next_valid", DW'(port_valid_out), DW'(4'b0010));
    step(1'b0, 2'd0, 1'b0, '0, 4'hF);
    #2;
    do_reset();

    // Wrap-around: push/pop pairs, mostly simultaneous.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'((i * 3) % 4), (i % 4 != 0), DW'(64'h100 + i), 4'hF);
      chk("wrap_max", DW'(outstanding_out <= 3'd4), DW'(1));
    end
    while (q.size() > 0) step(1'b0, 2'd0, 1'b1, DW'(64'h200), 4'hF);
    step(1'b0, 2'd0, 1'b0, '0, 4'hF);
    chk("wrap_error", DW'(error_out), DW'(0));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), rd, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/resp_router.md
# resp_router

Routes a single in-order response stream from the shared memory channel back to the requester port that issued each request. It sits on the return path opposite the request-side priority mux. It records the winning port ID of every accepted request in a tag FIFO, pops one tag per response, and drives the response into a one-entry output register steered to that port. Responses return in request order. There is no reordering.

## Interface
Parameters:
- DATA_WIDTH, 64, response payload width.
- PORTS, 2, number of requester ports (≥2).
- DEPTH, 4, maximum outstanding requests (tag FIFO entries, power of two ≥2).

Ports (ID_W = $clog2(PORTS), CNT_W = $clog2(DEPTH+1)):
- clk_in  input  1  sole clock; all state on rising edge.
- rst_N_in  input  1  reset, asynchronous assert, active-low.
- req_fire_in  input  1  a request from port req_id_in was accepted downstream this cycle.
- req_id_in  input  ID_W  originating port of the fired request.
- tag_full_out  output  1  tag FIFO full; the arbiter must not fire a request while high.
- outstanding_out  output  CNT_W  number of tags currently held.
- resp_valid_in  input  1  response beat present.
- resp_data_in  input  DATA_WIDTH  response payload.
- resp_ready_out  output  1  the router accepts the response this cycle.
- port_valid_out  output  [PORTS] one-hot (or zero) valid per port.
- port_data_out  output  DATA_WIDTH [PORTS] payload; all ports carry the registered data.
- port_ready_in  input  [PORTS] per-port consumer ready.
- error_out  output  1  sticky protocol error flag.

## Operation
- Tag FIFO: circular buffer with DEPTH entries, read/write pointers of log2(DEPTH) bits that wrap, and a count register.
- A push happens when req_fire_in=1 and count<DEPTH; it writes req_id_in.
- A pop happens when the response handshake fires (resp_valid_in && resp_ready_out).
- Output register: out_valid, out_id, and out_data.
  - port_valid_out[i] = out_valid && (out_id==i).
  - port_data_out[i] = out_data for all i.
- The output drains when out_valid && port_ready_in[out_id].
- resp_ready_out = (count>0) && (!out_valid || port_ready_in[out_id]). Combinational, with a full-throughput pass-through: a drain and a load can happen in the same cycle.
- On accept: out_data<=resp_data_in, out_id<=FIFO head, out_valid<=1.
- On drain without accept: out_valid<=0.
- port_ready_in of non-selected ports is ignored.
- Simultaneous push and pop: both occur and count is unchanged. This is also legal when count==DEPTH, because the pop frees the slot the same cycle only if count<DEPTH is evaluated after the pop. Decided: push is gated on count<DEPTH using the pre-pop count. So at full, a same-cycle push is dropped.
- No bypass: a tag pushed in cycle N is not usable for a response until cycle N+1. A response at count==0 is not accepted, even if a push occurs that cycle.
- error_out is set, and holds until reset, when either occurs:
  - req_fire_in=1 while count==DEPTH (the push is dropped);
  - resp_valid_in=1 while count==0 (the response is stalled, not dropped).
- req_id_in ≥ PORTS is stored as-is. A value ≥PORTS makes no port_valid_out bit assert, and the beat drains silently the following cycle. Decided behaviour: treat this as out_valid auto-clear.

## Timing
- Reset (rst_N_in low, async) forces:
  - count=0, pointers=0, outstanding_out=0, tag_full_out=0;
  - out_valid=0, port_valid_out=0, out_data=0, out_id=0;
  - error_out=0.
  - resp_ready_out=0, which follows from count=0.
  - Deassertion is sampled synchronously. The first push is possible on the first edge after release.
- Reset mid-operation discards all tags and any held beat. Nothing is replayed.
- Latency: response accepted at edge N gives port_valid_out at N (after the edge), i.e. one register stage. Throughput is one beat per cycle when the consumer is ready.
- tag_full_out = (count==DEPTH), registered-derived with no combinational path from inputs.
- outstanding_out = count, registered.
- resp_ready_out depends combinationally on port_ready_in.

## Test plan
- Reset: hold rst_N_in low mid-stream with 3 tags and out_valid=1. Every output must be 0 immediately, asynchronously, and stay 0 through release.
- In-order routing (PORTS=4): push IDs 2,0,3. Then send 0xA,0xB,0xC back-to-back with all ready. Required sequence: port_valid_out=0100 with 0xA, then 0001 with 0xB, then 1000 with 0xC. Outstanding must go 3→0.
- Back-pressure: port 1 holds a beat with port_ready_in[1]=0 while the next response is valid. resp_ready_out must stay 0 and the data must be stable. When ready rises, drain and load happen in the same cycle.
- Full (DEPTH=4): 4 pushes set tag_full_out=1. A 5th req_fire_in must set error_out=1 and leave the count at 4. Popping 1 clears tag_full_out.
- Empty: resp_valid_in with count 0 gives resp_ready_out=0 and error_out=1. A same-cycle push is not consumed until the next cycle.
- Wrap-around: run 10 push/pop pairs, some simultaneous, with DEPTH=4. Pointers wrap, the ID order is preserved, and outstanding never exceeds 4.
